// File: rtl/hq2x_timing_pkg.sv
// Shared types for the Hq2x output timing sequencer: the per-line measurement
// record that the line meter produces and the replay logic consumes.
package hq2x_timing_pkg;

  localparam int CNT_W_DEF = 12;
  // Record fields are sized for the widest supported counter; CNT_W must not exceed this.
  localparam int MEAS_W = 16;

  typedef struct packed {
    logic [MEAS_W-1:0] h_total;
    logic [MEAS_W-1:0] h_act;
    logic [MEAS_W-1:0] hs_off;
    logic [MEAS_W-1:0] hs_w;
    logic              meas_valid;
  } meas_t;

  localparam meas_t MEAS_RESET = '0;

endpackage

// File: rtl/hq2x_out_timing_meter.sv
// Input line meter: finds the hblank_in falling anchor, counts ticks per line and
// latches the measurement record of the line that just completed.
module hq2x_line_meter
  import hq2x_timing_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  ce_x4,
  input  logic  hblank_in,
  input  logic  hs_in,
  output logic  line_blank,
  output logic  anchor,
  output meas_t meas_nxt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             hblank_q, hblank_d;
  logic             hs_prev_q, hs_prev_d;
  logic             seen_q, seen_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic [CNT_W-1:0] acnt_q, acnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] hoff_q, hoff_d;
  meas_t            meas_q, meas_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  assign anchor     = ce_x4 & hblank_q & ~hblank_in;
  assign line_blank = hblank_q;
  assign meas_nxt   = meas_d;

  always_comb begin
    hblank_d  = hblank_q;
    hs_prev_d = hs_prev_q;
    seen_d    = seen_q;
    tcnt_d    = tcnt_q;
    acnt_d    = acnt_q;
    hcnt_d    = hcnt_q;
    hoff_d    = hoff_q;
    meas_d    = meas_q;
    if (ce_x4) begin
      hblank_d  = hblank_in;
      hs_prev_d = hs_in;
      if (anchor) begin
        meas_d.h_total    = MEAS_W'(tcnt_q + 1'b1);
        meas_d.h_act      = MEAS_W'(acnt_q);
        meas_d.hs_off     = MEAS_W'(hoff_q);
        meas_d.hs_w       = MEAS_W'(hcnt_q);
        // The very first anchor closes a line of unknown start, so it never validates.
        meas_d.meas_valid = seen_q & (tcnt_q != CNT_MAX);
        seen_d = 1'b1;
        tcnt_d = '0;
        acnt_d = CNT_W'(1'b1);
        hcnt_d = CNT_W'(hs_in);
        hoff_d = '0;
      end else begin
        tcnt_d = sat_inc(tcnt_q);
        if (!hblank_in) acnt_d = sat_inc(acnt_q);
        if (hs_in) hcnt_d = sat_inc(hcnt_q);
        if (hs_in && !hs_prev_q) hoff_d = sat_inc(tcnt_q);
        if (tcnt_d == CNT_MAX) meas_d.meas_valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hblank_q  <= 1'b0;
      hs_prev_q <= 1'b0;
      seen_q    <= 1'b0;
      tcnt_q    <= '0;
      acnt_q    <= '0;
      hcnt_q    <= '0;
      hoff_q    <= '0;
      meas_q    <= MEAS_RESET;
    end else begin
      hblank_q  <= hblank_d;
      hs_prev_q <= hs_prev_d;
      seen_q    <= seen_d;
      tcnt_q    <= tcnt_d;
      acnt_q    <= acnt_d;
      hcnt_q    <= hcnt_d;
      hoff_q    <= hoff_d;
      meas_q    <= meas_d;
    end
  end

endmodule

// File: rtl/hq2x_out_timing.sv
// Hq2x output timing: replays each measured input line as two half-length output
// lines and keeps the scaler's buffer parity and read_y in lock-step.
module hq2x_out_timing
  import hq2x_timing_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce_x4,
  input  logic       hblank_in,
  input  logic       vblank_in,
  input  logic       hs_in,
  input  logic       vs_in,
  output logic       reset_line,
  output logic       reset_frame,
  output logic       ce_out,
  output logic [1:0] read_y,
  output logic       hblank_out,
  output logic       hs_out,
  output logic       vs_out,
  output logic       vblank_out
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              anchor;
  meas_t             meas;

  logic              ce_out_q, ce_out_d;
  logic              frame_q, frame_d;
  logic [CNT_W-1:0]  ocnt_q, ocnt_d;
  logic              parity_q, parity_d;
  logic              ry1_q, ry1_d;
  logic              ry0_q, ry0_d;
  logic              vs_line_q, vs_line_d;
  logic              vb_line_q, vb_line_d;
  logic              vs_out_q, vs_out_d;
  logic              vblank_out_q, vblank_out_d;
  logic              hblank_out_q, hblank_out_d;
  logic              hs_out_q, hs_out_d;

  logic [CNT_W-1:0]  ocnt_nxt;
  logic [MEAS_W-1:0] oc, half0, sub, act_half, hs_start, hs_end;
  logic              sub_hi, frame_fall;

  hq2x_line_meter #(.CNT_W(CNT_W)) u_meter (
    .clk       (clk),
    .reset_n   (reset_n),
    .ce_x4     (ce_x4),
    .hblank_in (hblank_in),
    .hs_in     (hs_in),
    .line_blank(reset_line),
    .anchor    (anchor),
    .meas_nxt  (meas)
  );

  always_comb begin
    ce_out_d     = ce_x4;
    frame_d      = frame_q;
    ocnt_d       = ocnt_q;
    parity_d     = parity_q;
    ry1_d        = ry1_q;
    ry0_d        = ry0_q;
    vs_line_d    = vs_line_q;
    vb_line_d    = vb_line_q;
    vs_out_d     = vs_out_q;
    vblank_out_d = vblank_out_q;
    hblank_out_d = hblank_out_q;
    hs_out_d     = hs_out_q;

    // Output geometry is evaluated against the post-edge counter and record so that
    // the anchor tick already presents sub-line 0 of the new replay.
    frame_fall = frame_q & ~vblank_in;
    ocnt_nxt   = anchor ? '0 : ((ocnt_q == CNT_MAX) ? ocnt_q : ocnt_q + 1'b1);
    oc         = MEAS_W'(ocnt_nxt);
    half0      = meas.h_total >> 1;
    sub_hi     = (oc >= half0);
    sub        = sub_hi ? oc - half0 : oc;
    act_half   = meas.h_act >> 1;
    hs_start   = meas.hs_off >> 1;
    hs_end     = hs_start + (meas.hs_w >> 1);

    if (ce_x4) begin
      frame_d      = vblank_in;
      ocnt_d       = ocnt_nxt;
      ry0_d        = sub_hi;
      hblank_out_d = ~(meas.meas_valid && (sub < act_half));
      hs_out_d     = meas.meas_valid && (sub >= hs_start) && (sub < hs_end);
      if (anchor) begin
        vs_line_d    = vs_in;
        vb_line_d    = vblank_in;
        vs_out_d     = vs_line_q;
        vblank_out_d = vb_line_q;
        // read_y[1] names the buffer the completed line went into (pre-toggle parity).
        if (frame_fall) begin
          parity_d = 1'b0;
          ry1_d    = 1'b0;
        end else begin
          parity_d = ~parity_q;
          ry1_d    = parity_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ce_out_q     <= 1'b0;
      frame_q      <= 1'b0;
      ocnt_q       <= '0;
      parity_q     <= 1'b0;
      ry1_q        <= 1'b0;
      ry0_q        <= 1'b0;
      vs_line_q    <= 1'b0;
      vb_line_q    <= 1'b0;
      vs_out_q     <= 1'b0;
      vblank_out_q <= 1'b0;
      hblank_out_q <= 1'b1;
      hs_out_q     <= 1'b0;
    end else begin
      ce_out_q     <= ce_out_d;
      frame_q      <= frame_d;
      ocnt_q       <= ocnt_d;
      parity_q     <= parity_d;
      ry1_q        <= ry1_d;
      ry0_q        <= ry0_d;
      vs_line_q    <= vs_line_d;
      vb_line_q    <= vb_line_d;
      vs_out_q     <= vs_out_d;
      vblank_out_q <= vblank_out_d;
      hblank_out_q <= hblank_out_d;
      hs_out_q     <= hs_out_d;
    end
  end

  assign reset_frame = frame_q;
  assign ce_out      = ce_out_q;
  assign read_y      = {ry1_q, ry0_q};
  assign hblank_out  = hblank_out_q;
  assign hs_out      = hs_out_q;
  assign vs_out      = vs_out_q;
  assign vblank_out  = vblank_out_q;

endmodule
